// File: rtl/instr_packer_if.sv
// Byte-stream / instruction-word bundle between the file reader, the packer
// and the downstream decoder.
//
// Handshake semantics (both channels): a transfer happens on a rising clock
// edge exactly when the producer's valid and the consumer's ready are both 1.
// A producer may hold or change its data while ready is low; nothing is
// consumed until the edge where both are high.
interface instr_packer_if #(
    parameter int DEPTH = 4
);
    // Upstream byte channel
    logic [7:0]              byte_in;
    logic                    byte_valid;
    logic                    byte_last;
    logic                    byte_ready;

    // Downstream instruction channel
    logic [15:0]             instr_out;
    logic                    instr_pad;
    logic                    instr_valid;
    logic                    instr_ready;

    // FIFO occupancy, 0..DEPTH
    logic [$clog2(DEPTH):0]  fill_count;

    // Environment side: drives bytes in, consumes words out
    modport master (
        output byte_in,
        output byte_valid,
        output byte_last,
        output instr_ready,
        input  byte_ready,
        input  instr_out,
        input  instr_pad,
        input  instr_valid,
        input  fill_count
    );

    // Packer side
    modport slave (
        input  byte_in,
        input  byte_valid,
        input  byte_last,
        input  instr_ready,
        output byte_ready,
        output instr_out,
        output instr_pad,
        output instr_valid,
        output fill_count
    );
endinterface

// File: rtl/instr_packer.sv
// Packs a big-endian byte stream into 16-bit instruction words and queues
// them in a small FIFO for the decoder. An odd-length image ends with a
// word whose low byte is zero and whose pad flag is set.
module instr_packer #(
    parameter int DEPTH = 4
) (
    input  logic              clock,
    input  logic              reset,
    instr_packer_if.slave     bus,
    output logic              dbg_state
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH) + 1;

    typedef enum logic {
        LOW_WAIT  = 1'b0,
        HIGH_HELD = 1'b1
    } asm_state_t;

    asm_state_t        state_q;
    asm_state_t        state_d;
    logic [7:0]        held_q;
    logic [7:0]        held_d;

    logic [15:0]       mem_word [DEPTH];
    logic              mem_pad  [DEPTH];
    logic [AW-1:0]     wr_ptr_q;
    logic [AW-1:0]     rd_ptr_q;
    logic [CW-1:0]     count_q;
    logic              run_q;

    logic              accept;
    logic              pop;
    logic              push;
    logic [15:0]       push_word;
    logic              push_pad;

    // Ready is purely registered: it needs one edge out of reset (run_q)
    // and free space, and never looks at instr_ready, so a pop in the same
    // cycle cannot open the door to a byte while the FIFO is full.
    assign bus.byte_ready  = run_q && (count_q < CW'(DEPTH));
    assign bus.instr_valid = (count_q != '0);
    assign bus.fill_count  = count_q;

    assign accept = bus.byte_valid && bus.byte_ready;
    assign pop    = bus.instr_valid && bus.instr_ready;

    assign dbg_state = state_q;

    // Head of the FIFO, forced to zero when empty
    assign bus.instr_out = bus.instr_valid ? mem_word[rd_ptr_q] : 16'h0000;
    assign bus.instr_pad = bus.instr_valid ? mem_pad[rd_ptr_q]  : 1'b0;

    // Assembler state and held high byte
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= LOW_WAIT;
            held_q  <= 8'h00;
        end else begin
            state_q <= state_d;
            held_q  <= held_d;
        end
    end

    // Assembler next state and the word to push
    always_comb begin
        state_d   = state_q;
        held_d    = held_q;
        push      = 1'b0;
        push_word = 16'h0000;
        push_pad  = 1'b0;
        if (accept) begin
            case (state_q)
                LOW_WAIT: begin
                    if (bus.byte_last) begin
                        // Lone final byte: goes out as the high byte, padded
                        push      = 1'b1;
                        push_word = {bus.byte_in, 8'h00};
                        push_pad  = 1'b1;
                    end else begin
                        held_d  = bus.byte_in;
                        state_d = HIGH_HELD;
                    end
                end
                HIGH_HELD: begin
                    // Second byte always completes the word; byte_last here
                    // just means the image ended on an even boundary.
                    push      = 1'b1;
                    push_word = {held_q, bus.byte_in};
                    push_pad  = 1'b0;
                    state_d   = LOW_WAIT;
                end
                default: begin
                    state_d = LOW_WAIT;
                end
            endcase
        end
    end

    // FIFO storage write port
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_word[i] <= 16'h0000;
                mem_pad[i]  <= 1'b0;
            end
        end else if (push) begin
            mem_word[wr_ptr_q] <= push_word;
            mem_pad[wr_ptr_q]  <= push_pad;
        end
    end

    // FIFO pointers; DEPTH is a power of two so they wrap by overflow
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
        end
    end

    // Occupancy: simultaneous push and pop cancel out
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count_q <= '0;
        end else begin
            case ({push, pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Holds byte_ready low until the first edge after reset release
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            run_q <= 1'b0;
        end else begin
            run_q <= 1'b1;
        end
    end

endmodule

// File: tb/tb_instr_packer.sv
// Bench for instr_packer: directed table, hand-written corner sequences and
// a randomized run, all checked against a queue-based reference model.
module tb_instr_packer;

  localparam int DEPTH = 4;

  logic clock;
  logic reset;
  logic dbg_state;

  instr_packer_if #(.DEPTH(DEPTH)) bus();

  instr_packer #(.DEPTH(DEPTH)) dut (
    .clock     (clock),
    .reset     (reset),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Reference: ready comes up on the first rising edge after release
  logic m_up = 1'b0;
  always @(posedge clock or negedge reset) begin
    if (!reset) m_up = 1'b0;
    else        m_up = 1'b1;
  end

  // ---------------- scoreboard ----------------
  int total = 0;
  int bad   = 0;
  int pops  = 0;
  logic [16:0] exp_q[$];   // {pad, word} in FIFO order
  logic [7:0]  hold_q[$];  // unpaired high byte, at most one

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, want, $time);
    end
  endtask

  // Pair bytes big-endian; a final byte without a partner is padded
  task automatic model_byte(input logic [7:0] b, input logic last);
    logic [7:0] hi;
    if (hold_q.size() != 0) begin
      hi = hold_q.pop_front();
      exp_q.push_back({1'b0, hi, b});
    end else if (last) begin
      exp_q.push_back({1'b1, b, 8'h00});
    end else begin
      hold_q.push_back(b);
    end
  endtask

  logic mon_ready;
  logic mon_valid;

  // Monitor: compare outputs mid-cycle, then advance the model by the
  // transfers that the coming rising edge will perform.
  always @(negedge clock) begin
    if (!reset) begin
      check("rst_byte_ready", bus.byte_ready, 0);
      check("rst_instr_valid", bus.instr_valid, 0);
      check("rst_fill_count", bus.fill_count, 0);
      check("rst_instr_out", bus.instr_out, 0);
      check("rst_instr_pad", bus.instr_pad, 0);
      exp_q.delete();
      hold_q.delete();
    end else begin
      mon_valid = (exp_q.size() != 0);
      mon_ready = m_up && (exp_q.size() < DEPTH);
      check("byte_ready", bus.byte_ready, mon_ready);
      check("instr_valid", bus.instr_valid, mon_valid);
      check("fill_count", bus.fill_count, exp_q.size());
      if (mon_valid) begin
        check("instr_out", bus.instr_out, exp_q[0][15:0]);
        check("instr_pad", bus.instr_pad, exp_q[0][16]);
      end else begin
        check("idle_instr_out", bus.instr_out, 0);
        check("idle_instr_pad", bus.instr_pad, 0);
      end
      if (mon_valid && bus.instr_ready) begin
        void'(exp_q.pop_front());
        pops++;
      end
      if (bus.byte_valid && mon_ready) model_byte(bus.byte_in, bus.byte_last);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic last);
    logic acc;
    bus.byte_in    = b;
    bus.byte_last  = last;
    bus.byte_valid = 1'b1;
    for (int n = 0; n < 200; n++) begin
      @(negedge clock);
      acc = bus.byte_ready && reset;
      tick();
      if (acc) begin
        bus.byte_valid = 1'b0;
        return;
      end
    end
    check("send_timeout", 0, 1);
    bus.byte_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    bus.instr_ready = 1'b1;
    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      tick();
      n++;
    end
    tick();
    check("drain_left", exp_q.size(), 0);
    check("drain_valid", bus.instr_valid, 0);
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    logic [7:0]  b;
    logic        last;
    logic        exp_push;
    logic [15:0] exp_word;
    logic        exp_pad;
  } vec_t;

  vec_t vecs[11];

  initial begin
    #500000;
    $display("FAIL global_timeout: got running expected finished");
    bad++;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    logic acc;

    vecs[0]  = '{8'h12, 1'b0, 1'b0, 16'h0000, 1'b0};
    vecs[1]  = '{8'h34, 1'b0, 1'b1, 16'h1234, 1'b0};
    vecs[2]  = '{8'h56, 1'b0, 1'b0, 16'h0000, 1'b0};
    vecs[3]  = '{8'h78, 1'b0, 1'b1, 16'h5678, 1'b0};
    vecs[4]  = '{8'hAB, 1'b0, 1'b0, 16'h0000, 1'b0};
    vecs[5]  = '{8'hCD, 1'b0, 1'b1, 16'hABCD, 1'b0};
    vecs[6]  = '{8'hEF, 1'b1, 1'b1, 16'hEF00, 1'b1};
    vecs[7]  = '{8'h5A, 1'b1, 1'b1, 16'h5A00, 1'b1};
    vecs[8]  = '{8'h11, 1'b0, 1'b0, 16'h0000, 1'b0};
    vecs[9]  = '{8'h22, 1'b1, 1'b1, 16'h1122, 1'b0};
    vecs[10] = '{8'h33, 1'b1, 1'b1, 16'h3300, 1'b1};

    reset           = 1'b0;
    bus.byte_in     = 8'h00;
    bus.byte_valid  = 1'b0;
    bus.byte_last   = 1'b0;
    bus.instr_ready = 1'b0;

    repeat (3) tick();
    check("in_rst_ready", bus.byte_ready, 0);
    check("in_rst_fill", bus.fill_count, 0);
    reset = 1'b1;
    tick();
    check("ready_after_release", bus.byte_ready, 1);

    // Table: consecutive bytes, decoder always ready
    bus.instr_ready = 1'b1;
    for (int i = 0; i < 11; i++) begin
      bus.byte_in    = vecs[i].b;
      bus.byte_last  = vecs[i].last;
      bus.byte_valid = 1'b1;
      tick();
      check($sformatf("vec%0d_valid", i), bus.instr_valid, vecs[i].exp_push);
      check($sformatf("vec%0d_fill", i), bus.fill_count, vecs[i].exp_push);
      if (vecs[i].exp_push) begin
        check($sformatf("vec%0d_word", i), bus.instr_out, vecs[i].exp_word);
        check($sformatf("vec%0d_pad", i), bus.instr_pad, vecs[i].exp_pad);
      end
    end
    bus.byte_valid = 1'b0;
    bus.byte_last  = 1'b0;
    drain();

    // Backpressure: fill to DEPTH, byte held off even across the first pop
    bus.instr_ready = 1'b0;
    for (int i = 1; i <= 8; i++) send_byte(8'(i), 1'b0);
    check("full_fill", bus.fill_count, DEPTH);
    check("full_ready", bus.byte_ready, 0);
    bus.byte_in    = 8'h09;
    bus.byte_last  = 1'b0;
    bus.byte_valid = 1'b1;
    repeat (2) tick();
    check("full_hold_fill", bus.fill_count, DEPTH);
    bus.instr_ready = 1'b1;
    tick();
    check("full_pop_no_accept", bus.fill_count, DEPTH - 1);
    send_byte(8'h09, 1'b0);
    send_byte(8'h0A, 1'b0);
    drain();

    // Half full, push and pop every cycle across several pointer wraps
    bus.instr_ready = 1'b0;
    for (int i = 0; i < 4; i++) send_byte(8'hA1 + 8'(i), 1'b0);
    check("half_fill_start", bus.fill_count, 2);
    bus.instr_ready = 1'b1;
    for (int i = 0; i < 3 * DEPTH; i++) begin
      bus.byte_in    = 8'hB0 + 8'(i);
      bus.byte_last  = 1'b1;
      bus.byte_valid = 1'b1;
      tick();
      check("half_fill_steady", bus.fill_count, 2);
    end
    bus.byte_valid = 1'b0;
    bus.byte_last  = 1'b0;
    drain();

    // Reset pulse with a held byte and a queued word
    bus.instr_ready = 1'b0;
    send_byte(8'hC1, 1'b0);
    send_byte(8'hC2, 1'b0);
    send_byte(8'h9A, 1'b0);
    check("pre_rst_state", dbg_state, 1);
    reset = 1'b0;
    #5;
    reset = 1'b1;
    check("post_pulse_valid", bus.instr_valid, 0);
    check("post_pulse_fill", bus.fill_count, 0);
    check("post_pulse_state", dbg_state, 0);
    bus.instr_ready = 1'b1;
    send_byte(8'h01, 1'b0);
    check("post_pulse_no_word", bus.instr_valid, 0);
    send_byte(8'h02, 1'b0);
    check("post_pulse_word_valid", bus.instr_valid, 1);
    check("post_pulse_word", bus.instr_out, 16'h0102);
    check("post_pulse_pad", bus.instr_pad, 0);
    tick();
    check("post_pulse_single", bus.instr_valid, 0);

    // Random traffic on both channels
    acc = 1'b0;
    for (int cyc = 0; cyc < 1000; cyc++) begin
      if (acc || !bus.byte_valid) begin
        bus.byte_valid = 1'($urandom_range(0, 1));
        bus.byte_in    = 8'($urandom);
        bus.byte_last  = ($urandom_range(0, 7) == 0);
      end
      bus.instr_ready = 1'($urandom_range(0, 1));
      @(negedge clock);
      acc = bus.byte_valid && bus.byte_ready;
      tick();
    end
    bus.byte_valid = 1'b0;
    drain();
    check("random_pops_seen", (pops > 300), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
